led_request_scheduler: RTL and testbench
========================================

Name: led_request_scheduler

Overview:
- Sits directly upstream of the LED on-timer block and drives its led_index / led_request inputs.
- Accepts LED-hit events from game/detector logic through a valid/ready handshake and buffers them in a small FIFO.
- Filters out-of-range indices and paces the output so consecutive requests are a programmable number of cycles apart.
- Keeps bursty producers from being lost or overrunning the timer block.

Parameters:
- LED_COUNT, 18, number of LEDs; valid indices are 0..LED_COUNT-1.
- IDX_W, 5, width of LED index fields.
- FIFO_DEPTH, 8, event buffer depth; must be a power of 2 and >= 2.
- GAP_CYCLES, 4, idle cycles inserted after each issued request; 0 allows one request per cycle.

Ports:
- clk  in  1  system clock (rising edge).
- rst_n  in  1  asynchronous active-low reset.
- evt_valid  in  1  producer has an event on evt_index.
- evt_index  in  IDX_W  LED index of the event.
- evt_ready  out  1  scheduler can accept an event this cycle.
- led_index  out  IDX_W  index presented to the on-timer block.
- led_request  out  1  single-cycle request pulse to the on-timer block.
- fifo_count  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.
- drop_count  out  8  saturating count of discarded out-of-range events.

Behaviour:
- Reset (rst_n low, asynchronous, takes effect immediately):
  - FIFO emptied, fifo_count=0, drop_count=0.
  - led_request=0, led_index=0, FSM=IDLE, gap counter=0.
  - evt_ready=1 one cycle after rst_n deasserts; it is held 0 while in reset.
  - Reset mid-burst discards all buffered events; no request is issued for them.
- Handshake:
  - An event is accepted on a rising edge with evt_valid && evt_ready.
  - evt_ready = (fifo_count < FIFO_DEPTH), computed from registered occupancy only.
  - A pop in the same cycle does not free a slot for a write that cycle.
  - Producer must hold evt_valid/evt_index until accepted; nothing is dropped when full.
- Filtering:
  - An accepted event with evt_index >= LED_COUNT is consumed (ready honoured) but not written to the FIFO.
  - drop_count increments, saturating at 255.
  - In-range events are written in arrival order.
- FIFO: circular buffer with read/write pointers that wrap modulo FIFO_DEPTH. Push and pop in the same cycle leave fifo_count unchanged.
- FSM states IDLE, GAP:
  - IDLE, FIFO non-empty at the edge: pop head, register led_index<=head, led_request<=1 for exactly one cycle, gap counter<=GAP_CYCLES. Next state is GAP if GAP_CYCLES>0, else IDLE.
  - IDLE, FIFO empty: led_request<=0, stay in IDLE.
  - GAP: led_request<=0, gap counter decrements; when the counter equals 1 at the edge, next state is IDLE.
- Timing:
  - With a continuously non-empty FIFO, successive led_request pulses rise exactly GAP_CYCLES+1 cycles apart.
  - Latency: an event accepted at edge N into an empty FIFO with FSM in IDLE gives led_request high after edge N+1, so it is seen by the consumer at edge N+2.
  - Push to an empty FIFO and pop cannot occur at the same edge.
- led_index holds the last issued value between pulses.
- Duplicate indices are not merged; the downstream on-timer ignores re-requests for a lit LED.

Decomposition:
- Shared package/header led_pkg holds LED_COUNT, IDX_W and the FSM state encodings (IDLE=0, GAP=1), reused by the on-timer block.
- One sub-module, led_sync_fifo:
  - Parameters: width IDX_W, FIFO_DEPTH.
  - Ports: push, pop, din, dout, count, full, empty.
  - Async active-low reset.
- Scheduler top holds the filter, FSM, gap counter and drop counter.

Test Plan:
1. Reset then a single event index 3 accepted at edge N -> led_request pulses one cycle after edge N+1 with led_index=3; fifo_count returns to 0.
2. Burst of 10 events, indices 0..9, with evt_valid held; GAP_CYCLES=4, FIFO_DEPTH=8 -> evt_ready drops when fifo_count=8. All 10 are issued in order, pulses exactly 5 cycles apart, no losses.
3. Events with index 18, 25, 31 interleaved with index 7 -> only index 7 is issued; drop_count=3. Then 300 out-of-range events -> drop_count saturates at 255.
4. GAP_CYCLES=0 with 4 queued events -> led_request high for 4 consecutive cycles with led_index 4 values in order.
5. Assert rst_n low mid-burst with 5 events queued and FSM in GAP -> led_request=0, fifo_count=0, led_index=0 immediately. No further pulses after release until new events arrive.
6. Full FIFO with simultaneous pop and a valid event -> event is not accepted that cycle, is accepted the next cycle, and is issued in correct order.

Source files
------------

// File: rtl/led_pkg.sv
// led_pkg: LED constants and scheduler state encoding,
// shared with the LED on-timer block.
package led_pkg;

  localparam int LED_COUNT = 18;
  localparam int IDX_W     = 5;

  typedef enum logic {
    IDLE = 1'b0,
    GAP  = 1'b1
  } sched_state_e;

endpackage

// File: rtl/led_sync_fifo.sv
// led_sync_fifo: circular event buffer with wrapping
// read/write pointers and a registered occupancy count.
module led_sync_fifo #(
  parameter int WIDTH      = 5,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        push,
  input  logic                        pop,
  input  logic [WIDTH-1:0]            din,
  output logic [WIDTH-1:0]            dout,
  output logic [$clog2(FIFO_DEPTH):0] count,
  output logic                        full,
  output logic                        empty
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] mem [FIFO_DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CW'(FIFO_DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  // Storage needs no reset: count gates every read.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= din;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      unique case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/led_request_scheduler.sv
// led_request_scheduler: buffers LED-hit events, drops
// out-of-range indices, and paces requests to the on-timer.
module led_request_scheduler #(
  parameter int LED_COUNT  = led_pkg::LED_COUNT,
  parameter int IDX_W      = led_pkg::IDX_W,
  parameter int FIFO_DEPTH = 8,
  parameter int GAP_CYCLES = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        evt_valid,
  input  logic [IDX_W-1:0]            evt_index,
  output logic                        evt_ready,
  output logic [IDX_W-1:0]            led_index,
  output logic                        led_request,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count,
  output logic [7:0]                  drop_count
);

  import led_pkg::*;

  localparam int GW = $clog2(GAP_CYCLES + 2);
  localparam logic [IDX_W:0] LIMIT = LED_COUNT[IDX_W:0];

  sched_state_e     state;
  logic [GW-1:0]    gap_cnt;
  logic             alive;
  logic             accept;
  logic             in_range;
  logic             push;
  logic             pop;
  logic             full;
  logic             empty;
  logic [IDX_W-1:0] head;

  // Ready comes only from registered occupancy, so a pop
  // never frees a slot for a write in the same cycle.
  assign evt_ready = alive && !full;
  assign accept    = evt_valid && evt_ready;
  assign in_range  = ({1'b0, evt_index} < LIMIT);
  assign push      = accept && in_range;
  assign pop       = (state == IDLE) && !empty;

  led_sync_fifo #(
    .WIDTH      (IDX_W),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .din   (evt_index),
    .dout  (head),
    .count (fifo_count),
    .full  (full),
    .empty (empty)
  );

  // Holds evt_ready low through reset and its first edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alive <= 1'b0;
    end else begin
      alive <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_count <= '0;
    end else if (accept && !in_range && drop_count != 8'hFF) begin
      drop_count <= drop_count + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      gap_cnt     <= '0;
      led_request <= 1'b0;
      led_index   <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (!empty) begin
            led_index   <= head;
            led_request <= 1'b1;
            gap_cnt     <= GW'(GAP_CYCLES);
            state       <= (GAP_CYCLES > 0) ? GAP : IDLE;
          end else begin
            led_request <= 1'b0;
          end
        end
        GAP: begin
          led_request <= 1'b0;
          gap_cnt     <= gap_cnt - 1'b1;
          if (gap_cnt == GW'(1)) begin
            state <= IDLE;
          end
        end
        default: begin
          led_request <= 1'b0;
          state       <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_led_request_scheduler.sv
// tb_led_request_scheduler: directed checks of pacing,
// filtering, back-pressure and reset for the scheduler.
module tb_led_request_scheduler;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       evt_valid;
  logic [4:0] evt_index;
  logic       evt_ready;
  logic [4:0] led_index;
  logic       led_request;
  logic [3:0] fifo_count;
  logic [7:0] drop_count;

  logic       v0;
  logic [4:0] i0;
  logic       r0;
  logic [4:0] li0;
  logic       lr0;
  logic [3:0] fc0;
  logic [7:0] dc0;

  int checks = 0;
  int errors = 0;
  int npulse = 0;
  int cyc = 0;
  logic [4:0] last_idx = '0;

  led_request_scheduler #(
    .LED_COUNT  (18),
    .IDX_W      (5),
    .FIFO_DEPTH (8),
    .GAP_CYCLES (4)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .evt_valid   (evt_valid),
    .evt_index   (evt_index),
    .evt_ready   (evt_ready),
    .led_index   (led_index),
    .led_request (led_request),
    .fifo_count  (fifo_count),
    .drop_count  (drop_count)
  );

  led_request_scheduler #(
    .LED_COUNT  (18),
    .IDX_W      (5),
    .FIFO_DEPTH (8),
    .GAP_CYCLES (0)
  ) dut0 (
    .clk         (clk),
    .rst_n       (rst_n),
    .evt_valid   (v0),
    .evt_index   (i0),
    .evt_ready   (r0),
    .led_index   (li0),
    .led_request (lr0),
    .fifo_count  (fc0),
    .drop_count  (dc0)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rst_n && led_request) begin
      npulse++;
      last_idx = led_index;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d",
             tag, obs, exp);
    end
  endtask

  task automatic send(input logic [4:0] idx);
    bit done;
    done = 1'b0;
    evt_valid = 1'b1;
    evt_index = idx;
    for (int t = 0; t < 40 && !done; t++) begin
      done = evt_ready;
      tick();
    end
    chk("send_accept", 32'(done), 1);
    evt_valid = 1'b0;
  endtask

  initial begin
    int k;
    int np;
    int base;
    int last_cyc;
    int first_cyc;
    bit acc;
    bit saw_full;
    int acc_cyc [11];

    rst_n = 1'b0;
    evt_valid = 1'b0;
    evt_index = '0;
    v0 = 1'b0;
    i0 = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", 32'(evt_ready), 0);
    chk("rst_req", 32'(led_request), 0);
    chk("rst_idx", 32'(led_index), 0);
    chk("rst_count", 32'(fifo_count), 0);
    chk("rst_drop", 32'(drop_count), 0);
    rst_n = 1'b1;
    chk("rel_ready0", 32'(evt_ready), 0);
    tick();
    chk("rel_ready1", 32'(evt_ready), 1);

    // Single event, latency
    evt_valid = 1'b1;
    evt_index = 5'd3;
    tick();
    evt_valid = 1'b0;
    chk("t1_count1", 32'(fifo_count), 1);
    chk("t1_req0", 32'(led_request), 0);
    tick();
    chk("t1_req1", 32'(led_request), 1);
    chk("t1_idx", 32'(led_index), 3);
    chk("t1_count0", 32'(fifo_count), 0);
    tick();
    chk("t1_req_off", 32'(led_request), 0);
    chk("t1_idx_hold", 32'(led_index), 3);
    repeat (8) tick();

    // Burst of 11 with valid held; last one meets a full FIFO
    k = 0;
    np = 0;
    saw_full = 1'b0;
    last_cyc = 0;
    first_cyc = 0;
    cyc = 0;
    evt_valid = 1'b1;
    evt_index = 5'd0;
    for (int t = 0; t < 80; t++) begin
      acc = evt_valid && evt_ready;
      tick();
      if (acc) begin
        acc_cyc[k] = cyc;
        k++;
        if (k < 11) evt_index = 5'(k);
        else evt_valid = 1'b0;
      end
      if (fifo_count == 4'd8) begin
        chk("full_ready", 32'(evt_ready), 0);
        saw_full = 1'b1;
      end
      if (led_request) begin
        chk("burst_idx", 32'(led_index), 32'(np));
        if (np > 0) chk("burst_gap", 32'(cyc - last_cyc), 5);
        else first_cyc = cyc;
        last_cyc = cyc;
        np++;
      end
    end
    chk("burst_accepts", 32'(k), 11);
    chk("burst_pulses", 32'(np), 11);
    chk("burst_first", 32'(first_cyc), 2);
    chk("burst_last", 32'(last_cyc), 52);
    chk("burst_saw_full", 32'(saw_full), 1);
    chk("acc9_cyc", 32'(acc_cyc[9]), 10);
    chk("acc10_cyc", 32'(acc_cyc[10]), 13);
    chk("burst_empty", 32'(fifo_count), 0);

    // Filtering and drop saturation
    base = npulse;
    send(5'd18);
    send(5'd7);
    send(5'd25);
    send(5'd31);
    repeat (10) tick();
    chk("flt_pulses", 32'(npulse - base), 1);
    chk("flt_idx", 32'(last_idx), 7);
    chk("flt_drop", 32'(drop_count), 3);
    evt_valid = 1'b1;
    evt_index = 5'd20;
    repeat (100) tick();
    chk("drop_103", 32'(drop_count), 103);
    repeat (200) tick();
    evt_valid = 1'b0;
    chk("drop_sat", 32'(drop_count), 255);
    tick();
    chk("drop_hold", 32'(drop_count), 255);
    chk("drop_fifo", 32'(fifo_count), 0);
    chk("drop_pulses", 32'(npulse - base), 1);

    // GAP_CYCLES=0: back-to-back requests
    v0 = 1'b1;
    i0 = 5'd11;
    tick();
    chk("g0_req0", 32'(lr0), 0);
    i0 = 5'd12;
    tick();
    chk("g0_req_a", 32'(lr0), 1);
    chk("g0_idx_a", 32'(li0), 11);
    i0 = 5'd13;
    tick();
    chk("g0_req_b", 32'(lr0), 1);
    chk("g0_idx_b", 32'(li0), 12);
    i0 = 5'd14;
    tick();
    chk("g0_req_c", 32'(lr0), 1);
    chk("g0_idx_c", 32'(li0), 13);
    v0 = 1'b0;
    tick();
    chk("g0_req_d", 32'(lr0), 1);
    chk("g0_idx_d", 32'(li0), 14);
    tick();
    chk("g0_req_off", 32'(lr0), 0);
    chk("g0_idx_hold", 32'(li0), 14);
    chk("g0_empty", 32'(fc0), 0);

    // Reset mid-burst with 5 queued and FSM in GAP
    evt_valid = 1'b1;
    for (int j = 1; j <= 7; j++) begin
      evt_index = 5'(j);
      tick();
    end
    evt_valid = 1'b0;
    chk("mid_count", 32'(fifo_count), 5);
    chk("mid_req", 32'(led_request), 1);
    chk("mid_idx", 32'(led_index), 2);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_req", 32'(led_request), 0);
    chk("arst_count", 32'(fifo_count), 0);
    chk("arst_idx", 32'(led_index), 0);
    chk("arst_ready", 32'(evt_ready), 0);
    chk("arst_drop", 32'(drop_count), 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    base = npulse;
    repeat (20) tick();
    chk("post_rst_quiet", 32'(npulse - base), 0);
    chk("post_rst_ready", 32'(evt_ready), 1);
    send(5'd9);
    repeat (3) tick();
    chk("post_rst_pulse", 32'(npulse - base), 1);
    chk("post_rst_idx", 32'(last_idx), 9);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
